// File: rtl/clock_timekeeper_if.sv
// Tick/button inputs and display-facing outputs of the time-of-day counter.
interface clock_timekeeper_if;
  logic       tick_in;
  logic       mode_btn;
  logic       inc_btn;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       pm;
  logic [1:0] mode;
  logic       blink;
  logic       sec_pulse;

  modport master (
    output tick_in, mode_btn, inc_btn,
    input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    input  pm, mode, blink, sec_pulse
  );

  modport slave (
    input  tick_in, mode_btn, inc_btn,
    output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
    output pm, mode, blink, sec_pulse
  );
endinterface

// File: rtl/clock_timekeeper.sv
// BCD hh:mm:ss counter advanced by a synchronised 1 Hz tick, with a two-button
// hour/minute set mode.
module clock_timekeeper #(
  parameter bit H24 = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  clock_timekeeper_if.slave bus
);
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_e;

  mode_e         mode_q, mode_d;
  logic          s1_q, s2_q, prev_q;
  logic [DW-1:0] hr_tens_q, hr_ones_q, min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic          pm_q, blink_q, sec_pulse_q;

  logic          tick;
  logic          sec_wrap, min_wrap;
  logic [DW-1:0] hr_tens_d, hr_ones_d, min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic          pm_d;

  assign tick = s2_q & ~prev_q;

  always_comb begin
    mode_d = mode_q;
    if (bus.mode_btn) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        default: mode_d = RUN;
      endcase
    end
  end

  // Each field's +1 value with its own wrap; the sequential block decides carries
  always_comb begin
    sec_wrap   = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    sec_ones_d = (sec_ones_q == 4'd9) ? 4'd0 : sec_ones_q + 4'd1;
    sec_tens_d = sec_tens_q;
    if (sec_ones_q == 4'd9) begin
      sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
    end

    min_wrap   = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
    min_ones_d = (min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
    min_tens_d = min_tens_q;
    if (min_ones_q == 4'd9) begin
      min_tens_d = (min_tens_q == 4'd5) ? 4'd0 : min_tens_q + 4'd1;
    end

    hr_tens_d = hr_tens_q;
    hr_ones_d = hr_ones_q + 4'd1;
    pm_d      = pm_q;
    if (H24) begin
      if ((hr_tens_q == 4'd2) && (hr_ones_q == 4'd3)) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd0;
      end else if (hr_ones_q == 4'd9) begin
        hr_tens_d = hr_tens_q + 4'd1;
        hr_ones_d = 4'd0;
      end
    end else begin
      // 12-hour face: 12 -> 01, and pm flips only when 11 rolls into 12
      if ((hr_tens_q == 4'd1) && (hr_ones_q == 4'd2)) begin
        hr_tens_d = 4'd0;
        hr_ones_d = 4'd1;
      end else if ((hr_tens_q == 4'd1) && (hr_ones_q == 4'd1)) begin
        hr_tens_d = 4'd1;
        hr_ones_d = 4'd2;
        pm_d      = ~pm_q;
      end else if (hr_ones_q == 4'd9) begin
        hr_tens_d = 4'd1;
        hr_ones_d = 4'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      mode_q      <= RUN;
      blink_q     <= 1'b0;
      sec_pulse_q <= 1'b0;
      hr_tens_q   <= H24 ? 4'd0 : 4'd1;
      hr_ones_q   <= H24 ? 4'd0 : 4'd2;
      min_tens_q  <= 4'd0;
      min_ones_q  <= 4'd0;
      sec_tens_q  <= 4'd0;
      sec_ones_q  <= 4'd0;
      pm_q        <= 1'b0;
    end else begin
      s1_q        <= bus.tick_in;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      mode_q      <= mode_d;
      blink_q     <= (mode_d != RUN) && s2_q;
      sec_pulse_q <= 1'b0;
      case (mode_q)
        RUN: begin
          if (tick) begin
            sec_pulse_q <= 1'b1;
            sec_ones_q  <= sec_ones_d;
            sec_tens_q  <= sec_tens_d;
            if (sec_wrap) begin
              min_ones_q <= min_ones_d;
              min_tens_q <= min_tens_d;
              if (min_wrap) begin
                hr_ones_q <= hr_ones_d;
                hr_tens_q <= hr_tens_d;
                pm_q      <= pm_d;
              end
            end
          end
        end
        SET_HR: begin
          if (!bus.mode_btn && bus.inc_btn) begin
            hr_ones_q <= hr_ones_d;
            hr_tens_q <= hr_tens_d;
            pm_q      <= pm_d;
          end
        end
        SET_MIN: begin
          // Leaving set mode restarts the minute; a coincident tick is dropped
          if (bus.mode_btn) begin
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
          end else if (bus.inc_btn) begin
            min_ones_q <= min_ones_d;
            min_tens_q <= min_tens_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hr_tens   = hr_tens_q;
  assign bus.hr_ones   = hr_ones_q;
  assign bus.min_tens  = min_tens_q;
  assign bus.min_ones  = min_ones_q;
  assign bus.sec_tens  = sec_tens_q;
  assign bus.sec_ones  = sec_ones_q;
  assign bus.pm        = pm_q;
  assign bus.mode      = mode_q;
  assign bus.blink     = blink_q;
  assign bus.sec_pulse = sec_pulse_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// Drives a 24-hour and a 12-hour timekeeper with shared stimulus and checks both
// against an integer time model and a per-instance expected-advance queue.
module tb_clock_timekeeper;
  logic clk = 1'b0;
  logic rst, tick_in, mode_btn, inc_btn;
  int   checks = 0;
  int   errors = 0;

  clock_timekeeper_if b24 ();
  clock_timekeeper_if b12 ();

  assign b24.tick_in  = tick_in;
  assign b24.mode_btn = mode_btn;
  assign b24.inc_btn  = inc_btn;
  assign b12.tick_in  = tick_in;
  assign b12.mode_btn = mode_btn;
  assign b12.inc_btn  = inc_btn;

  clock_timekeeper #(.H24(1'b1)) dut24 (.CLK(clk), .RST(rst), .bus(b24));
  clock_timekeeper #(.H24(1'b0)) dut12 (.CLK(clk), .RST(rst), .bus(b12));

  always #5 clk = ~clk;

  // Reference model: plain integers, index 0 = 24-hour, index 1 = 12-hour
  int          mh[2], mm[2], ms[2];
  bit          mpm[2];
  int          mmode;
  logic [24:0] q24[$], q12[$];
  logic [24:0] mon_e24, mon_e12;

  function automatic logic [24:0] mexp(int i);
    return {4'(mh[i] / 10), 4'(mh[i] % 10), 4'(mm[i] / 10), 4'(mm[i] % 10),
            4'(ms[i] / 10), 4'(ms[i] % 10), mpm[i]};
  endfunction

  function automatic logic [24:0] snap(int i);
    if (i == 0)
      return {b24.hr_tens, b24.hr_ones, b24.min_tens, b24.min_ones,
              b24.sec_tens, b24.sec_ones, b24.pm};
    return {b12.hr_tens, b12.hr_ones, b12.min_tens, b12.min_ones,
            b12.sec_tens, b12.sec_ones, b12.pm};
  endfunction

  function automatic void m_reset();
    mh[0] = 0; mh[1] = 12;
    for (int i = 0; i < 2; i++) begin
      mm[i] = 0; ms[i] = 0; mpm[i] = 1'b0;
    end
    mmode = 0;
    q24.delete();
    q12.delete();
  endfunction

  function automatic void m_inc_hr(int i);
    if (i == 0) mh[0] = (mh[0] + 1) % 24;
    else if (mh[1] == 11) begin mh[1] = 12; mpm[1] = ~mpm[1]; end
    else if (mh[1] == 12) mh[1] = 1;
    else mh[1] = mh[1] + 1;
  endfunction

  function automatic void m_tick();
    if (mmode != 0) return;
    for (int i = 0; i < 2; i++) begin
      ms[i] = ms[i] + 1;
      if (ms[i] == 60) begin
        ms[i] = 0;
        mm[i] = mm[i] + 1;
        if (mm[i] == 60) begin
          mm[i] = 0;
          m_inc_hr(i);
        end
      end
    end
    q24.push_back(mexp(0));
    q12.push_back(mexp(1));
  endfunction

  function automatic void m_mode();
    if (mmode == 2) begin ms[0] = 0; ms[1] = 0; end
    mmode = (mmode + 1) % 3;
  endfunction

  function automatic void m_inc();
    for (int i = 0; i < 2; i++) begin
      if (mmode == 1) m_inc_hr(i);
      else if (mmode == 2) mm[i] = (mm[i] + 1) % 60;
    end
  endfunction

  // Scoreboard: every sec_pulse must match the next expected advance
  always @(negedge clk) begin
    if (!rst && b24.sec_pulse) begin
      checks++;
      if (q24.size() == 0) begin
        errors++; $display("FAIL sb24_advance unexpected sec_pulse time=%h", snap(0));
      end else begin
        mon_e24 = q24.pop_front();
        if (snap(0) !== mon_e24) begin
          errors++; $display("FAIL sb24_time got=%h expected=%h", snap(0), mon_e24);
        end
      end
    end
    if (!rst && b12.sec_pulse) begin
      checks++;
      if (q12.size() == 0) begin
        errors++; $display("FAIL sb12_advance unexpected sec_pulse time=%h", snap(1));
      end else begin
        mon_e12 = q12.pop_front();
        if (snap(1) !== mon_e12) begin
          errors++; $display("FAIL sb12_time got=%h expected=%h", snap(1), mon_e12);
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    m_mode();
  endtask

  task automatic press_inc(input int n);
    for (int k = 0; k < n; k++) begin
      inc_btn = 1'b1;
      @(negedge clk);
      inc_btn = 1'b0;
      m_inc();
    end
  endtask

  task automatic run_tick();
    m_tick();
    tick_in = 1'b1;
    repeat (4) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q24.size() + q12.size() != 0) begin
      errors++; $display("FAIL tick_drain pending=%0d required=0", q24.size() + q12.size());
    end
  endtask

  task automatic freeze_tick();
    tick_in = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (b24.blink !== 1'b1) begin
      errors++; $display("FAIL blink_set got=%b required=1", b24.blink);
    end
    checks++;
    if (snap(0) !== mexp(0) || snap(1) !== mexp(1)) begin
      errors++; $display("FAIL set_frozen got=%h/%h required=%h/%h", snap(0), snap(1), mexp(0), mexp(1));
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [24:0] e12;
    e12 = {4'd1, 4'd2, 16'd0, 1'b0};
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (snap(0) !== 25'd0) begin errors++; $display("FAIL reset24 got=%h required=0", snap(0)); end
    checks++;
    if (snap(1) !== e12) begin errors++; $display("FAIL reset12 got=%h required=%h", snap(1), e12); end
    checks++;
    if ({b24.mode, b12.mode, b24.sec_pulse, b24.blink} !== 6'd0) begin
      errors++; $display("FAIL reset_ctl got=%b required=000000", {b24.mode, b12.mode, b24.sec_pulse, b24.blink});
    end
    rst = 1'b0;
    m_reset();
    m_tick();
    tick_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (b24.sec_ones !== ((k == 3) ? 4'd1 : 4'd0)) begin
        errors++; $display("FAIL tick_latency edge=%0d got=%0d required=%0d", k, b24.sec_ones, (k == 3) ? 1 : 0);
      end
    end
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_preload_wrap();
    logic [24:0] e [2];
    e[0] = {4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0};
    e[1] = 25'd0;
    press_mode(); press_inc(23); press_mode(); press_inc(59); press_mode();
    checks++;
    if (snap(0) !== {4'd2, 4'd3, 4'd5, 4'd9, 8'd0, 1'b0} || b24.mode !== 2'b00) begin
      errors++; $display("FAIL preload got=%h mode=%b required=2359000 mode=00", snap(0), b24.mode);
    end
    repeat (58) run_tick();
    for (int k = 0; k < 2; k++) begin
      m_tick();
      tick_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (b24.sec_pulse !== 1'b1 || snap(0) !== e[k]) begin
        errors++; $display("FAIL wrap24 step=%0d got=%h pulse=%b required=%h pulse=1", k, snap(0), b24.sec_pulse, e[k]);
      end
      @(negedge clk);
      checks++;
      if (b24.sec_pulse !== 1'b0) begin
        errors++; $display("FAIL pulse_width step=%0d got=%b required=0", k, b24.sec_pulse);
      end
      tick_in = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_12h_wrap();
    press_mode();
    for (int k = 0; k < 24 && !(mh[1] == 11 && mpm[1] == 1'b0); k++) press_inc(1);
    press_mode();
    for (int k = 0; k < 60 && mm[1] != 59; k++) press_inc(1);
    press_mode();
    for (int k = 0; k < 60 && ms[1] != 59; k++) run_tick();
    checks++;
    if (snap(1) !== {4'd1, 4'd1, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0}) begin
      errors++; $display("FAIL pre_noon got=%h required=115959 am", snap(1));
    end
    run_tick();
    checks++;
    if (snap(1) !== {4'd1, 4'd2, 16'd0, 1'b1}) begin
      errors++; $display("FAIL noon got=%h required=120000 pm", snap(1));
    end
    press_mode(); press_mode();
    for (int k = 0; k < 60 && mm[1] != 59; k++) press_inc(1);
    press_mode();
    for (int k = 0; k < 60 && ms[1] != 59; k++) run_tick();
    checks++;
    if (snap(1) !== {4'd1, 4'd2, 4'd5, 4'd9, 4'd5, 4'd9, 1'b1}) begin
      errors++; $display("FAIL pre_one got=%h required=125959 pm", snap(1));
    end
    run_tick();
    checks++;
    if (snap(1) !== {4'd0, 4'd1, 16'd0, 1'b1}) begin
      errors++; $display("FAIL one_pm got=%h required=010000 pm", snap(1));
    end
  endtask

  task automatic test_set_sequence();
    logic [24:0] e;
    e = {4'd0, 4'd1, 4'd0, 4'd1, 8'd0, 1'b0};
    do_reset(1);
    press_mode(); press_inc(25); freeze_tick();
    press_mode(); press_inc(61); freeze_tick();
    press_mode();
    checks++;
    if (snap(0) !== e || snap(1) !== e) begin
      errors++; $display("FAIL set_seq got=%h/%h required=%h", snap(0), snap(1), e);
    end
    checks++;
    if (b24.mode !== 2'b00 || b24.blink !== 1'b0) begin
      errors++; $display("FAIL set_exit mode=%b blink=%b required mode=00 blink=0", b24.mode, b24.blink);
    end
  endtask

  task automatic test_simultaneous();
    press_mode();
    mode_btn = 1'b1; inc_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0; inc_btn = 1'b0;
    m_mode();
    checks++;
    if (b24.mode !== 2'b10 || snap(0) !== mexp(0) || snap(1) !== mexp(1)) begin
      errors++; $display("FAIL mode_beats_inc mode=%b got=%h required mode=10 %h", b24.mode, snap(0), mexp(0));
    end
    press_mode();
    m_tick();
    tick_in = 1'b1;
    repeat (10) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap(0) !== mexp(0) || snap(1) !== mexp(1) || q24.size() != 0) begin
      errors++; $display("FAIL held_tick got=%h required=%h", snap(0), mexp(0));
    end
    m_tick(); m_mode();
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    checks++;
    if (b24.mode !== 2'b01 || b24.sec_pulse !== 1'b1 || snap(0) !== mexp(0)) begin
      errors++; $display("FAIL tick_enter_set mode=%b pulse=%b got=%h required mode=01 pulse=1 %h", b24.mode, b24.sec_pulse, snap(0), mexp(0));
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    press_mode();
    m_mode();
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    mode_btn = 1'b1;
    @(negedge clk);
    mode_btn = 1'b0;
    checks++;
    if (b24.mode !== 2'b00 || b24.sec_pulse !== 1'b0 || {b24.sec_tens, b24.sec_ones} !== 8'd0 || snap(0) !== mexp(0)) begin
      errors++; $display("FAIL tick_leave_set mode=%b pulse=%b got=%h required mode=00 pulse=0 %h", b24.mode, b24.sec_pulse, snap(0), mexp(0));
    end
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_set();
    do_reset(1);
    press_mode(); press_inc(7); press_mode(); press_inc(42);
    checks++;
    if (b24.mode !== 2'b10 || snap(0) !== {4'd0, 4'd7, 4'd4, 4'd2, 8'd0, 1'b0}) begin
      errors++; $display("FAIL pre_reset mode=%b got=%h required mode=10 074200", b24.mode, snap(0));
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (snap(0) !== 25'd0 || snap(1) !== {4'd1, 4'd2, 16'd0, 1'b0} || b24.mode !== 2'b00) begin
      errors++; $display("FAIL reset_in_set got=%h/%h mode=%b required=0/%h mode=00", snap(0), snap(1), b24.mode, {4'd1, 4'd2, 16'd0, 1'b0});
    end
    rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    m_reset();
    test_reset();
    test_preload_wrap();
    test_12h_wrap();
    test_set_sequence();
    test_simultaneous();
    test_reset_in_set();
    checks++;
    if (q24.size() + q12.size() != 0) begin
      errors++; $display("FAIL leftover_expected pending=%0d required=0", q24.size() + q12.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
